// File: rtl/mult_share_arbiter_if.sv
// Requester and multiplier channels of mult_share_arbiter.
// The arbiter connects through the master view and the environment through the slave view.
interface mult_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int A_BITS  = 130,
    parameter int B_BITS  = 128,
    parameter int P_BITS  = 258
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*A_BITS-1:0] req_a;
    logic [NUM_REQ*B_BITS-1:0] req_b;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [P_BITS-1:0]         rsp_product;
    logic                      rsp_err;
    logic                      mul_start;
    logic [A_BITS-1:0]         mul_a;
    logic [B_BITS-1:0]         mul_b;
    logic [P_BITS-1:0]         mul_product;
    logic                      mul_busy;
    logic                      mul_done;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready, mul_product, mul_busy, mul_done,
        output req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready, mul_product, mul_busy, mul_done,
        input  req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multiplier among NUM_REQ requesters, one operation
// at a time, with a completion watchdog and a completed-operation counter.
module mult_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int A_BITS         = 130,
    parameter int B_BITS         = 128,
    parameter int P_BITS         = 258,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    mult_share_arbiter_if.master       bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [15:0]                op_count
);
    localparam int          ID_W    = $clog2(NUM_REQ);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   next_idx;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic [15:0]       wdog;
    logic [A_BITS-1:0] sel_a;
    logic [B_BITS-1:0] sel_b;

    // Search starts one past the last served requester and wraps, so the
    // requester just served has the lowest priority.
    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last_grant) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

    assign sel_a = bus.req_a[32'(next_idx)*A_BITS +: A_BITS];
    assign sel_b = bus.req_b[32'(next_idx)*B_BITS +: B_BITS];

    assign bus.req_ready = (reset_n && state == IDLE && found) ?
                           (NUM_REQ'(1) << next_idx) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            last_grant      <= ID_W'(NUM_REQ - 1);
            grant_id        <= '0;
            wdog            <= '0;
            op_count        <= '0;
            bus.mul_start   <= 1'b0;
            bus.mul_a       <= '0;
            bus.mul_b       <= '0;
            bus.rsp_valid   <= '0;
            bus.rsp_product <= '0;
            bus.rsp_err     <= 1'b0;
        end else begin
            bus.mul_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        bus.mul_a <= sel_a;
                        bus.mul_b <= sel_b;
                        grant_id  <= next_idx;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.mul_busy) begin
                        bus.mul_start <= 1'b1;
                        wdog          <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mul_done) begin
                        bus.rsp_product <= bus.mul_product;
                        bus.rsp_err     <= 1'b0;
                        bus.rsp_valid   <= NUM_REQ'(1) << grant_id;
                        state           <= RESP;
                    end else if (wdog == WD_LAST) begin
                        bus.rsp_product <= {P_BITS{1'b0}};
                        bus.rsp_err     <= 1'b1;
                        bus.rsp_valid   <= NUM_REQ'(1) << grant_id;
                        state           <= RESP;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[grant_id]) begin
                        bus.rsp_valid <= '0;
                        last_grant    <= grant_id;
                        op_count      <= op_count + 16'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a simple fixed-latency multiplier model.
module tb_mult_share_arbiter;
    localparam int NR  = 4;
    localparam int AB  = 130;
    localparam int BB  = 128;
    localparam int PB  = 258;
    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  grant_id;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    mult_share_arbiter_if #(.NUM_REQ(NR), .A_BITS(AB), .B_BITS(BB), .P_BITS(PB)) bus ();

    mult_share_arbiter #(
        .NUM_REQ(NR), .A_BITS(AB), .B_BITS(BB), .P_BITS(PB), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .grant_id(grant_id), .op_count(op_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int start_count = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int rsp_cyc = 0;
    int cnt = 0;
    bit never_done = 0;
    bit force_busy = 0;
    logic [PB-1:0] la, lb;

    always @(posedge clk) cyc++;

    // Multiplier model: latches operands on start, busy for LAT cycles, then pulses done.
    initial begin
        bus.mul_busy = 1'b0;
        bus.mul_done = 1'b0;
        bus.mul_product = '0;
        forever begin
            @(posedge clk); #1;
            bus.mul_done = 1'b0;
            if (!reset_n) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !never_done) begin
                    bus.mul_done = 1'b1;
                    bus.mul_product = la * lb;
                    done_cyc = cyc;
                end
            end else if (bus.mul_start) begin
                la = PB'(bus.mul_a);
                lb = PB'(bus.mul_b);
                cnt = LAT;
                start_count++;
                start_cyc = cyc;
            end
            bus.mul_busy = force_busy || (cnt > 0);
        end
    end

    task automatic check(input string tag, input logic [PB-1:0] got, input logic [PB-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(output int g);
        int n = 0;
        g = -1;
        #1;
        while (bus.req_ready == '0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("grant_seen", PB'(|bus.req_ready), 1);
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) g = i;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (bus.rsp_valid == '0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        rsp_cyc = cyc;
        check("rsp_seen", PB'(|bus.rsp_valid), 1);
    endtask

    task automatic do_op(input int idx, input logic [AB-1:0] a, input logic [BB-1:0] b,
                         input logic [PB-1:0] exp_p, input logic exp_err, input string tag);
        int g;
        logic [NR-1:0] oh;
        oh = NR'(1) << idx;
        bus.req_a[idx*AB +: AB] = a;
        bus.req_b[idx*BB +: BB] = b;
        bus.req_valid[idx] = 1'b1;
        wait_grant(g);
        check({tag, "_grant"}, PB'(g), PB'(idx));
        @(posedge clk); #1;
        bus.req_valid[idx] = 1'b0;
        check({tag, "_mul_a"}, PB'(bus.mul_a), PB'(a));
        check({tag, "_grant_id"}, PB'(grant_id), PB'(idx));
        wait_rsp();
        check({tag, "_rsp_valid"}, PB'(bus.rsp_valid), PB'(oh));
        check({tag, "_product"}, bus.rsp_product, exp_p);
        check({tag, "_err"}, PB'(bus.rsp_err), PB'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        int g;
        int s0;
        int bad;
        int n;
        logic [PB-1:0] max_exp;
        logic [PB-1:0] rr_exp [NR];
        logic [AB-1:0] max_a;
        logic [BB-1:0] max_b;

        bus.req_valid = 4'b0100;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", PB'(bus.req_ready), 0);
        check("rst_outs", PB'({bus.rsp_valid, bus.rsp_err, bus.mul_start}), 0);
        check("rst_mul_a", PB'(bus.mul_a), 0);
        check("rst_op_count", PB'(op_count), 0);
        check("rst_product", bus.rsp_product, 0);
        bus.req_valid = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        s0 = start_count;
        do_op(0, 3, 5, 15, 1'b0, "single");
        check("single_done_to_rsp", PB'(rsp_cyc - done_cyc), 1);
        check("single_starts", PB'(start_count - s0), 1);
        check("single_op_count", PB'(op_count), 1);

        max_a = '1;
        max_b = '1;
        max_exp = '1;
        max_exp = max_exp - (PB'(1) << 130) - (PB'(1) << 128) + PB'(2);
        do_op(3, max_a, max_b, max_exp, 1'b0, "max");

        rr_exp[0] = 14; rr_exp[1] = 24; rr_exp[2] = 36; rr_exp[3] = 50;
        for (int k = 0; k < NR; k++) begin
            bus.req_a[k*AB +: AB] = AB'(k + 2);
            bus.req_b[k*BB +: BB] = BB'(k + 7);
        end
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            check("rr_grant", PB'(g), PB'(k % NR));
            @(posedge clk); #1;
            if (k == 4) bus.req_valid = '0;
            wait_rsp();
            check("rr_route", PB'(bus.rsp_valid), PB'(4'b0001 << (k % NR)));
            check("rr_product", bus.rsp_product, rr_exp[k % NR]);
            @(posedge clk); #1;
        end

        bus.rsp_ready[1] = 1'b0;
        do_op(1, 100, 200, 20000, 1'b0, "bp");
        check("bp_op_count_hold", PB'(op_count), 7);
        bus.req_a[0 +: AB] = 1;
        bus.req_b[0 +: BB] = 1;
        bus.req_valid[0] = 1'b1;
        bad = 0;
        repeat (50) begin
            @(posedge clk); #2;
            if (bus.rsp_valid !== 4'b0010 || bus.rsp_product !== PB'(20000) ||
                bus.req_ready !== 4'b0000 || op_count !== 16'd7) bad++;
        end
        check("bp_stable", PB'(bad), 0);
        bus.rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", PB'(bus.rsp_valid), 0);
        check("bp_release_count", PB'(op_count), 8);
        wait_grant(g);
        check("bp_next_grant", PB'(g), 0);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_rsp();
        check("bp_next_product", bus.rsp_product, 1);
        @(posedge clk); #1;

        never_done = 1'b1;
        do_op(2, 7, 9, 0, 1'b1, "timeout");
        check("timeout_latency", PB'(rsp_cyc - start_cyc), 10);
        never_done = 1'b0;
        do_op(3, 6, 7, 42, 1'b0, "after_timeout");
        check("after_timeout_count", PB'(op_count), 11);

        force_busy = 1'b1;
        @(posedge clk); #1;
        bus.req_a[1*AB +: AB] = 9;
        bus.req_b[1*BB +: BB] = 11;
        bus.req_valid[1] = 1'b1;
        wait_grant(g);
        check("busy_grant", PB'(g), 1);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        s0 = start_count;
        repeat (5) begin @(posedge clk); #1; end
        check("busy_no_start", PB'(start_count - s0), 0);
        check("busy_start_low", PB'(bus.mul_start), 0);
        force_busy = 1'b0;
        wait_rsp();
        check("busy_product", bus.rsp_product, 99);
        check("busy_starts", PB'(start_count - s0), 1);
        @(posedge clk); #1;

        never_done = 1'b1;
        s0 = start_count;
        bus.req_a[3*AB +: AB] = 2;
        bus.req_b[3*BB +: BB] = 2;
        bus.req_valid[3] = 1'b1;
        wait_grant(g);
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        n = 0;
        while (start_count == s0 && n < 50) begin @(posedge clk); #1; n++; end
        check("wait_start_seen", PB'(start_count - s0), 1);
        repeat (3) begin @(posedge clk); #1; end
        bus.req_a[0 +: AB] = 4;
        bus.req_b[0 +: BB] = 4;
        bus.req_a[2*AB +: AB] = 5;
        bus.req_b[2*BB +: BB] = 5;
        bus.req_valid = 4'b0101;
        reset_n = 1'b0;
        #1;
        check("midrst_req_ready", PB'(bus.req_ready), 0);
        check("midrst_outs", PB'({bus.rsp_valid, bus.rsp_err, bus.mul_start}), 0);
        check("midrst_mul_a", PB'(bus.mul_a), 0);
        check("midrst_mul_b", PB'(bus.mul_b), 0);
        check("midrst_grant_id", PB'(grant_id), 0);
        check("midrst_op_count", PB'(op_count), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        never_done = 1'b0;
        wait_grant(g);
        check("midrst_first_grant", PB'(g), 0);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_rsp();
        check("midrst_product", bus.rsp_product, 16);
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        check("midrst_op_count_after", PB'(op_count), 1);
        repeat (3) begin @(posedge clk); #1; end
        check("drop_no_grant", PB'(grant_id), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
